adc_sample_sched: RTL and testbench

//  Sequences the serial ADC receiver for the servo loop: issues periodic conversion

---
 rtl/adc_sched_pkg.sv | 21 ++
 rtl/adc_sample_sched_sync_edge.sv | 27 ++
 rtl/adc_sample_sched.sv | 175 +++++++++++++++++
 tb/tb_adc_sample_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types and helpers for the ADC sample scheduler.
package adc_sched_pkg;

  localparam int DATA_W_DEF = 12;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    CHECK     = 3'd4,
    ACCUM     = 3'd5,
    OUTPUT    = 3'd6
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_sample_sched_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign pulse = sync_p1 & ~prev_p2;

endmodule

// File: rtl/adc_sample_sched.sv
// Periodic conversion scheduler for the serial ADC receiver: start pulses, done/timeout
// handling, frame validation and power-of-two averaging into a filtered sample.
module adc_sample_sched
  import adc_sched_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SAMPLE_DIV = 50000,
  parameter int START_HOLD = 64,
  parameter int TIMEOUT    = 4096,
  parameter int AVG_LOG2   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear_err,
  input  logic              rx_listo,
  input  logic [DATA_W-1:0] dato_adc,
  input  logic [3:0]        bits_zero,
  output logic              inicio_rx,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic              frame_err,
  output logic              overrun_err
);

  localparam int TICK_W = cnt_w(SAMPLE_DIV);
  localparam int HOLD_W = cnt_w(START_HOLD);
  localparam int TO_W   = cnt_w(TIMEOUT);
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);

  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] a);
    return a[ACC_W-1:AVG_LOG2];
  endfunction

  state_t              state;
  state_t              next_state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   dato_p0;
  logic [3:0]          bits_p0;
  logic                done_p;
  logic                tick;
  logic                timeout_hit;
  logic                frame_hit;
  logic                overrun_hit;
  logic                start_entry;

  sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (rx_listo),
    .pulse (done_p)
  );

  assign tick        = en && (tick_cnt == TICK_LAST);
  assign timeout_hit = (state == WAIT_DONE) && !done_p && (to_cnt == TO_LAST);
  assign frame_hit   = (state == CHECK) && (bits_p0 != 4'd0);
  // A tick is only consumable from IDLE/WAIT_TICK; anywhere else it is dropped and flagged.
  assign overrun_hit = tick && (state != IDLE) && (state != WAIT_TICK);
  assign start_entry = (next_state == START) && (state != START);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (en) next_state = WAIT_TICK;
      WAIT_TICK: begin
        if (!en)       next_state = IDLE;
        else if (tick) next_state = START;
      end
      START:     if (hold_cnt == HOLD_LAST) next_state = en ? WAIT_DONE : IDLE;
      WAIT_DONE: begin
        if (done_p)           next_state = en ? CHECK : IDLE;
        else if (timeout_hit) next_state = en ? WAIT_TICK : IDLE;
      end
      CHECK: begin
        if (!en)                    next_state = IDLE;
        else if (bits_p0 != 4'd0)   next_state = WAIT_TICK;
        else                        next_state = ACCUM;
      end
      ACCUM: begin
        if (!en)                  next_state = IDLE;
        else if (cnt == CNT_LAST) next_state = OUTPUT;
        else                      next_state = WAIT_TICK;
      end
      OUTPUT:    next_state = en ? WAIT_TICK : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      inicio_rx <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      inicio_rx <= (next_state == START);
      busy      <= !(next_state inside {IDLE, WAIT_TICK});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      hold_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      if (!en || tick) tick_cnt <= '0;
      else             tick_cnt <= tick_cnt + 1'b1;

      if (state != START) hold_cnt <= '0;
      else                hold_cnt <= hold_cnt + 1'b1;

      // Timeout window runs from the first START cycle through WAIT_DONE.
      if (start_entry)
        to_cnt <= '0;
      else if ((state == START || state == WAIT_DONE) && to_cnt != TO_LAST)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  // ---- capture stage: receiver word registered on the done pulse
  always_ff @(posedge clk) begin
    if (state == WAIT_DONE && done_p) begin
      dato_p0 <= dato_adc;
      bits_p0 <= bits_zero;
    end
  end

  // ---- accumulate / output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= (state == OUTPUT);
      if (state == OUTPUT) sample <= avg_trunc(acc);

      if (next_state == IDLE || timeout_hit || state == OUTPUT) begin
        acc <= '0;
        cnt <= '0;
      end else if (state == ACCUM) begin
        acc <= acc + ACC_W'(dato_p0);
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A new error in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit | (timeout_err & ~clear_err);
      frame_err   <= frame_hit   | (frame_err   & ~clear_err);
      overrun_err <= overrun_hit | (overrun_err & ~clear_err);
    end
  end

endmodule

// File: tb/tb_adc_sample_sched.sv
// Scoreboard bench for adc_sample_sched with a behavioural ADC receiver model.
`timescale 1ns/1ps
module tb_adc_sample_sched;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, clear_err, rx_listo;
  logic [DW-1:0] dato_adc;
  logic [3:0]    bits_zero;
  logic          inicio_rx, sample_valid, busy, timeout_err, frame_err, overrun_err;
  logic [DW-1:0] sample;

  logic          en2, clear2, rx2;
  logic [DW-1:0] dato2;
  logic [3:0]    bz2;
  logic          ini2, svld2, busy2, to2, fe2, ov2;
  logic [DW-1:0] sample2;

  int total = 0;
  int bad = 0;
  int vld_cnt = 0;
  int frames_done = 0;
  int cyc = 0;
  int ini2_rises = 0;
  int ini2_last = 0;
  logic ini2_q = 1'b0;
  bit resp_en = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] dq[$];
  logic [3:0]    bq[$];
  logic [DW-1:0] e;

  always #5 clk = ~clk;

  adc_sample_sched #(.DATA_W(DW), .SAMPLE_DIV(100), .START_HOLD(4), .TIMEOUT(40), .AVG_LOG2(2)) dut (
    .clk(clk), .rst(rst), .en(en), .clear_err(clear_err), .rx_listo(rx_listo),
    .dato_adc(dato_adc), .bits_zero(bits_zero), .inicio_rx(inicio_rx), .sample(sample),
    .sample_valid(sample_valid), .busy(busy), .timeout_err(timeout_err),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );

  adc_sample_sched #(.DATA_W(DW), .SAMPLE_DIV(100), .START_HOLD(4), .TIMEOUT(200), .AVG_LOG2(2)) dut_ov (
    .clk(clk), .rst(rst), .en(en2), .clear_err(clear2), .rx_listo(rx2),
    .dato_adc(dato2), .bits_zero(bz2), .inicio_rx(ini2), .sample(sample2),
    .sample_valid(svld2), .busy(busy2), .timeout_err(to2),
    .frame_err(fe2), .overrun_err(ov2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic queue_frame(input logic [DW-1:0] d, input logic [3:0] b);
    dq.push_back(d);
    bq.push_back(b);
  endtask

  task automatic wait_vld(input int target, input int maxc, input string name);
    int n;
    n = 0;
    while (vld_cnt < target && n < maxc) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(vld_cnt >= target), 1);
  endtask

  // Returns just after the clock edge on which inicio_rx went high.
  task automatic wait_start(input int maxc, output bit ok);
    logic prev;
    prev = inicio_rx;
    ok = 1'b0;
    for (int n = 0; n < maxc && !ok; n++) begin
      @(posedge clk);
      #1;
      if (inicio_rx && !prev) ok = 1'b1;
      prev = inicio_rx;
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ini2 && !ini2_q) begin
      ini2_rises++;
      ini2_last = cyc;
    end
    ini2_q = ini2;
  end

  // Monitor: every sample_valid pulse is matched against the oldest expected sample.
  always @(negedge clk) begin
    if (!rst && sample_valid) begin
      vld_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sample_unexpected: got %0h expected none", sample);
      end else begin
        e = exp_q.pop_front();
        if (sample !== e) begin
          bad++;
          $display("FAIL sample: got %0h expected %0h", sample, e);
        end
      end
    end
  end

  // Receiver model: answers 10 clocks after each start with the next queued frame.
  initial begin
    rx_listo = 1'b0;
    dato_adc = '0;
    bits_zero = '0;
    forever begin
      @(posedge inicio_rx);
      repeat (10) @(posedge clk);
      #1;
      if (resp_en && dq.size() > 0) begin
        dato_adc = dq.pop_front();
        bits_zero = bq.pop_front();
        rx_listo = 1'b1;
        frames_done++;
        repeat (6) @(posedge clk);
        #1 rx_listo = 1'b0;
      end
    end
  end

  // Slow receiver for the overrun instance: answers 120 clocks after each start.
  initial begin
    rx2 = 1'b0;
    dato2 = 12'h123;
    bz2 = 4'd0;
    forever begin
      @(posedge ini2);
      repeat (120) @(posedge clk);
      #1 rx2 = 1'b1;
      repeat (6) @(posedge clk);
      #1 rx2 = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int v0, fd0, t1, t2, t3, n;
    rst = 1'b1; en = 1'b0; clear_err = 1'b0; en2 = 1'b0; clear2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inicio", 32'(inicio_rx), 0);
    check("rst_sample", 32'(sample), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_errs", 32'({timeout_err, frame_err, overrun_err}), 0);
    check("rst_inicio2", 32'(ini2), 0);
    @(negedge clk) rst = 1'b0;

    // basic average of four good frames
    queue_frame(12'h100, 4'd0); queue_frame(12'h104, 4'd0);
    queue_frame(12'h108, 4'd0); queue_frame(12'h10C, 4'd0);
    exp_q.push_back(12'h106);
    resp_en = 1'b1;
    en = 1'b1;
    wait_vld(1, 600, "t1_valid");
    check("t1_errs", 32'({timeout_err, frame_err, overrun_err}), 0);

    // receiver never answers: timeout exactly 40 clocks after start
    resp_en = 1'b0;
    wait_start(150, ok);
    check("t2_start", 32'(ok), 1);
    v0 = vld_cnt;
    repeat (39) @(posedge clk);
    #1;
    check("t2_to_early", 32'(timeout_err), 0);
    check("t2_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    check("t2_to_set", 32'(timeout_err), 1);
    wait_start(150, ok);
    check("t2_restart", 32'(ok), 1);
    check("t2_no_valid", 32'(vld_cnt), 32'(v0));
    clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
    check("t2_clear", 32'(timeout_err), 0);

    // bad third frame is dropped; output after five frames averages the four good ones
    queue_frame(12'h200, 4'd0); queue_frame(12'h210, 4'd0);
    queue_frame(12'h7FF, 4'b0010);
    queue_frame(12'h220, 4'd0); queue_frame(12'h230, 4'd0);
    exp_q.push_back(12'h218);
    resp_en = 1'b1;
    wait_vld(2, 700, "t3_valid");
    check("t3_frame_err", 32'(frame_err), 1);
    check("t3_other_errs", 32'({timeout_err, overrun_err}), 0);
    resp_en = 1'b0;
    clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
    check("t3_clear", 32'(frame_err), 0);

    // reset during WAIT_DONE, then a truncating average after resume
    wait_start(150, ok);
    check("t5_start", 32'(ok), 1);
    repeat (6) @(posedge clk);
    #1;
    check("t5_busy_pre", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_inicio", 32'(inicio_rx), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_sample", 32'(sample), 0);
    check("t5_valid", 32'(sample_valid), 0);
    check("t5_errs", 32'({timeout_err, frame_err, overrun_err}), 0);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    queue_frame(12'h050, 4'd0); queue_frame(12'h051, 4'd0);
    queue_frame(12'h052, 4'd0); queue_frame(12'h057, 4'd0);
    exp_q.push_back(12'h052);
    resp_en = 1'b1;
    wait_vld(3, 700, "t5_valid_resume");

    // enable dropped after two accumulated samples
    fd0 = frames_done;
    queue_frame(12'h300, 4'd0); queue_frame(12'h310, 4'd0);
    n = 0;
    while (frames_done < fd0 + 2 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("t6_two_frames", 32'(frames_done >= fd0 + 2), 1);
    repeat (20) @(posedge clk);
    #1 en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6_idle_busy", 32'(busy), 0);
    repeat (150) @(posedge clk);
    #1;
    check("t6_no_start", 32'(frames_done), 32'(fd0 + 2));
    check("t6_no_valid", 32'(vld_cnt), 3);
    check("t6_sample_held", 32'(sample), 'h052);
    queue_frame(12'h400, 4'd0); queue_frame(12'h404, 4'd0);
    queue_frame(12'h408, 4'd0); queue_frame(12'h40C, 4'd0);
    exp_q.push_back(12'h406);
    en = 1'b1;
    wait_vld(4, 700, "t6_valid_fresh");

    // overrun on the slow-receiver instance: every other tick dropped
    en = 1'b0;
    resp_en = 1'b0;
    en2 = 1'b1;
    n = 0;
    while (ini2_rises < 1 && n < 200) begin @(posedge clk); n++; end
    t1 = ini2_last;
    n = 0;
    while (ini2_rises < 2 && n < 300) begin @(posedge clk); n++; end
    t2 = ini2_last;
    n = 0;
    while (ini2_rises < 3 && n < 300) begin @(posedge clk); n++; end
    t3 = ini2_last;
    #1;
    check("t4_starts", 32'(ini2_rises), 3);
    check("t4_gap1", 32'(t2 - t1), 200);
    check("t4_gap2", 32'(t3 - t2), 200);
    check("t4_overrun", 32'(ov2), 1);
    check("t4_no_timeout", 32'({to2, fe2}), 0);

    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
